// File: rtl/vga_frame_reader_pkg.sv
// vga_frame_reader_pkg: 640x480@60 timing constants, frame-buffer geometry and RGB444 pixel fields
package vga_frame_reader_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int FB_AW    = 19;
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;
endpackage

// File: rtl/vga_frame_reader_timing_gen.sv
// vga_timing_gen: stage-0 h/v counters producing active0, hs0, vs0 (active low) and frame_end
//  clk, rst                      pixel clock, async active-high reset
//  active0, hs0, vs0, frame_end  combinational decodes of the counter state
module vga_timing_gen
    import vga_frame_reader_pkg::*;
#(
    parameter int HA  = H_ACTIVE,
    parameter int HFP = H_FP,
    parameter int HS  = H_SYNC,
    parameter int HB  = H_BP,
    parameter int VA  = V_ACTIVE,
    parameter int VFP = V_FP,
    parameter int VS  = V_SYNC,
    parameter int VB  = V_BP
) (
    input  logic clk,
    input  logic rst,
    output logic active0,
    output logic hs0,
    output logic vs0,
    output logic frame_end
);
    localparam logic [9:0] H_VIS  = 10'(HA);
    localparam logic [9:0] H_SS   = 10'(HA + HFP);
    localparam logic [9:0] H_SE   = 10'(HA + HFP + HS);
    localparam logic [9:0] H_LAST = 10'(HA + HFP + HS + HB - 1);
    localparam logic [9:0] V_VIS  = 10'(VA);
    localparam logic [9:0] V_SS   = 10'(VA + VFP);
    localparam logic [9:0] V_SE   = 10'(VA + VFP + VS);
    localparam logic [9:0] V_LAST = 10'(VA + VFP + VS + VB - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
            if (h_cnt == H_LAST)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    assign active0   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs0       = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    assign vs0       = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans the frame buffer in raster order and drives aligned RGB444 + VGA syncs
//  clk, rst            pixel clock, async active-high reset
//  rd_addr, rd_en      frame-buffer read port (rd_en only on visible pixels)
//  rd_data             {R,G,B} valid RD_LAT clocks after rd_en
//  vga_r/g/b, vga_hs/vs registered pins, RD_LAT+1 clocks behind the counters
//  frame_end           stage-0 pulse on the last clock of each frame
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int HA     = H_ACTIVE,
    parameter int HFP    = H_FP,
    parameter int HS     = H_SYNC,
    parameter int HB     = H_BP,
    parameter int VA     = V_ACTIVE,
    parameter int VFP    = V_FP,
    parameter int VS     = V_SYNC,
    parameter int VB     = V_BP,
    parameter int RD_LAT = 1,
    parameter int AW     = FB_AW
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    input  logic [11:0]   rd_data,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          frame_end
);
    logic              active0;
    logic              hs0;
    logic              vs0;
    logic [AW-1:0]     addr_cnt;
    logic [RD_LAT-1:0] act_d;
    logic [RD_LAT-1:0] hs_d;
    logic [RD_LAT-1:0] vs_d;
    rgb444_t           px;

    vga_timing_gen #(
        .HA(HA), .HFP(HFP), .HS(HS), .HB(HB),
        .VA(VA), .VFP(VFP), .VS(VS), .VB(VB)
    ) u_timing (
        .clk(clk),
        .rst(rst),
        .active0(active0),
        .hs0(hs0),
        .vs0(vs0),
        .frame_end(frame_end)
    );

    assign rd_addr = addr_cnt;
    // counters sit at (0,0) during reset, which decodes as visible
    assign rd_en   = active0 & ~rst;
    assign px      = rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= '0;
            act_d    <= '0;
            hs_d     <= '1;
            vs_d     <= '1;
            vga_r    <= '0;
            vga_g    <= '0;
            vga_b    <= '0;
            vga_hs   <= 1'b1;
            vga_vs   <= 1'b1;
        end else begin
            addr_cnt <= frame_end ? '0 : addr_cnt + AW'(active0);
            act_d    <= RD_LAT'({act_d, active0});
            hs_d     <= RD_LAT'({hs_d, hs0});
            vs_d     <= RD_LAT'({vs_d, vs0});
            vga_r    <= act_d[RD_LAT-1] ? px.r : '0;
            vga_g    <= act_d[RD_LAT-1] ? px.g : '0;
            vga_b    <= act_d[RD_LAT-1] ? px.b : '0;
            vga_hs   <= hs_d[RD_LAT-1];
            vga_vs   <= vs_d[RD_LAT-1];
        end
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: scoreboard bench over several latencies/geometries, with a random mid-frame reset
module tb_vga_frame_reader;
    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } pix_t;

    logic clk;
    logic rst;
    logic done;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s u%0d got %0h want %0h at %0t", nm, g, a, e, $time);
        end
    endtask

    for (genvar g = 0; g < 5; g++) begin : u
        localparam int  L    = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 2 : 1;
        localparam bit  BIG  = (g == 4);
        localparam bit  LEAK = (g == 3);
        localparam int  HA   = BIG ? 640 : 20;
        localparam int  HFP  = BIG ? 16 : 2;
        localparam int  HS   = BIG ? 96 : 3;
        localparam int  HB   = BIG ? 48 : 5;
        localparam int  VA   = BIG ? 480 : 12;
        localparam int  VFP  = BIG ? 10 : 2;
        localparam int  VS   = 2;
        localparam int  VB   = BIG ? 33 : 3;
        localparam int  HT   = HA + HFP + HS + HB;
        localparam int  VT   = VA + VFP + VS + VB;
        localparam int  FB   = HA * VA;

        logic [18:0] rd_addr;
        logic        rd_en;
        logic [11:0] rd_data;
        logic [3:0]  vr, vgr, vb;
        logic        hs, vs, fe;
        logic [11:0] ram [L];
        pix_t        q[$];
        int          n;
        int          fe_cnt;
        int          fe_exp;

        vga_frame_reader #(
            .HA(HA), .HFP(HFP), .HS(HS), .HB(HB),
            .VA(VA), .VFP(VFP), .VS(VS), .VB(VB),
            .RD_LAT(L), .AW(19)
        ) dut (
            .clk(clk),
            .rst(rst),
            .rd_addr(rd_addr),
            .rd_en(rd_en),
            .rd_data(rd_data),
            .vga_r(vr),
            .vga_g(vgr),
            .vga_b(vb),
            .vga_hs(hs),
            .vga_vs(vs),
            .frame_end(fe)
        );

        assign rd_data = LEAK ? 12'hFFF : ram[L-1];

        always @(posedge clk) begin
            ram[0] <= rd_en ? rd_addr[11:0] : 12'($urandom);
            for (int i = 1; i < L; i++) ram[i] <= ram[i-1];
        end

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                for (int i = 0; i <= L; i++) q.push_back('{12'h000, 1'b1, 1'b1});
                n = 0;
            end else begin
                int h, v, ea;
                bit vis, last;
                h    = n % HT;
                v    = (n / HT) % VT;
                vis  = (h < HA) && (v < VA);
                last = (h == HT - 1) && (v == VT - 1);
                ea   = (v < VA) ? v * HA + ((h < HA) ? h : HA) : FB;
                chk("rd_en", g, 32'(rd_en), 32'(vis));
                chk("rd_addr", g, 32'(rd_addr), ea);
                chk("frame_end", g, 32'(fe), 32'(last));
                q.push_back('{vis ? (LEAK ? 12'hFFF : 12'(v * HA + h)) : 12'h000,
                              !((h >= HA + HFP) && (h < HA + HFP + HS)),
                              !((v >= VA + VFP) && (v < VA + VFP + VS))});
                if (fe) fe_cnt++;
                if (last) fe_exp++;
                n++;
            end
        end

        always @(negedge clk) begin
            #1;
            if (!rst && q.size() > 0) begin
                pix_t e;
                e = q.pop_front();
                chk("rgb", g, 32'({vr, vgr, vb}), 32'(e.rgb));
                chk("hs", g, 32'(hs), 32'(e.hs));
                chk("vs", g, 32'(vs), 32'(e.vs));
            end
        end

        always @(posedge rst) begin
            #1;
            chk("rst_rgb", g, 32'({vr, vgr, vb}), 0);
            chk("rst_hs", g, 32'(hs), 1);
            chk("rst_vs", g, 32'(vs), 1);
            chk("rst_rd_en", g, 32'(rd_en), 0);
            chk("rst_rd_addr", g, 32'(rd_addr), 0);
            chk("rst_frame_end", g, 32'(fe), 0);
        end

        always @(posedge done) chk("frame_count", g, fe_cnt, fe_exp);

        initial begin
            fe_cnt = 0;
            fe_exp = 0;
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        done  = 1'b0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (1500 + $urandom_range(0, 300)) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (1300) @(posedge clk);
        done = 1'b1;
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
